// File: rtl/aes_dec_seq.sv
`default_nettype none
// ============================================================================
// Module   : aes_dec_seq
// Purpose  : Control sequencer for the AES inverse cipher. After a host start
//            it waits out key expansion, loads the ciphertext with rk[NR],
//            then steps InvShiftRows -> InvSubBytes -> AddRoundKey ->
//            InvMixColumns per round while indexing round keys downward to 0.
//            The last round skips InvMixColumns. The result is held in FIN
//            until the host acknowledges it.
// Ports    : clk   - clock, rising edge
//            res   - asynchronous active-low reset
//            start - request decryption (sampled only in IDL)
//            ack   - host acknowledge (sampled only in FIN)
//            cs    - current state code
//            rnd   - round-key index for ARK/LDA
//            busy  - cs is neither IDL nor FIN
//            done  - cs is FIN
//            ld/isr/isb/ark/imc - one-hot datapath step enables
// Revision : 1.0 - initial release
// ============================================================================
module aes_dec_seq #(
  parameter int NR      = 10,
  parameter int PRE_CYC = 10
) (
  input  logic       clk,
  input  logic       res,
  input  logic       start,
  input  logic       ack,
  output logic [2:0] cs,
  output logic [3:0] rnd,
  output logic       busy,
  output logic       done,
  output logic       ld,
  output logic       isr,
  output logic       isb,
  output logic       ark,
  output logic       imc
);

  typedef enum logic [2:0] {
    IDL = 3'b000,
    KEX = 3'b001,
    LDA = 3'b010,
    ISR = 3'b011,
    ISB = 3'b100,
    ARK = 3'b101,
    IMC = 3'b110,
    FIN = 3'b111
  } state_e;

  localparam logic [3:0] NR_C     = 4'(NR);
  // Terminal count of the key-wait counter; unused when PRE_CYC is 0.
  localparam logic [7:0] KEX_LAST = 8'(PRE_CYC - 1);

  state_e     cs_q, cs_d;
  logic [3:0] rnd_q, rnd_d;
  logic [7:0] kcnt_q, kcnt_d;

  logic busy_q, done_q, ld_q, isr_q, isb_q, ark_q, imc_q;

  always_comb begin
    cs_d   = cs_q;
    rnd_d  = rnd_q;
    kcnt_d = kcnt_q;
    case (cs_q)
      IDL: begin
        if (start) begin
          rnd_d  = NR_C;
          kcnt_d = 8'd0;
          cs_d   = (PRE_CYC == 0) ? LDA : KEX;
        end
      end
      KEX: begin
        if (kcnt_q == KEX_LAST) begin
          cs_d   = LDA;
          kcnt_d = 8'd0;
        end else begin
          kcnt_d = kcnt_q + 8'd1;
        end
      end
      LDA: begin
        cs_d = ISR;
        if (rnd_q != 4'd0) rnd_d = rnd_q - 4'd1;
      end
      ISR: cs_d = ISB;
      ISB: cs_d = ARK;
      // The round that consumes rk[0] is the final one: no InvMixColumns.
      ARK: cs_d = (rnd_q == 4'd0) ? FIN : IMC;
      IMC: begin
        cs_d = ISR;
        if (rnd_q != 4'd0) rnd_d = rnd_q - 4'd1;
      end
      FIN: begin
        if (ack) cs_d = IDL;
      end
      default: begin
        cs_d   = IDL;
        rnd_d  = 4'd0;
        kcnt_d = 8'd0;
      end
    endcase
  end

  // Flags are registered from the next-state decode so that they always
  // equal a decode of the registered state, without a combinational path.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      cs_q   <= IDL;
      rnd_q  <= 4'd0;
      kcnt_q <= 8'd0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ld_q   <= 1'b0;
      isr_q  <= 1'b0;
      isb_q  <= 1'b0;
      ark_q  <= 1'b0;
      imc_q  <= 1'b0;
    end else begin
      cs_q   <= cs_d;
      rnd_q  <= rnd_d;
      kcnt_q <= kcnt_d;
      busy_q <= (cs_d != IDL) && (cs_d != FIN);
      done_q <= (cs_d == FIN);
      ld_q   <= (cs_d == LDA);
      isr_q  <= (cs_d == ISR);
      isb_q  <= (cs_d == ISB);
      ark_q  <= (cs_d == ARK);
      imc_q  <= (cs_d == IMC);
    end
  end

  assign cs   = cs_q;
  assign rnd  = rnd_q;
  assign busy = busy_q;
  assign done = done_q;
  assign ld   = ld_q;
  assign isr  = isr_q;
  assign isb  = isb_q;
  assign ark  = ark_q;
  assign imc  = imc_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_dec_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_dec_seq
// Purpose  : Self-checking bench for aes_dec_seq. Three instances cover the
//            default configuration, NR=1/PRE_CYC=0 and PRE_CYC=255. Expected
//            per-cycle output vectors are queued when stimulus is applied and
//            compared as the DUT advances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_dec_seq;

  logic clk = 1'b0;
  logic res;
  logic start0, ack0, start1, ack1, start2, ack2;

  logic [2:0] cs0, cs1, cs2;
  logic [3:0] rnd0, rnd1, rnd2;
  logic busy0, done0, ld0, isr0, isb0, ark0, imc0;
  logic busy1, done1, ld1, isr1, isb1, ark1, imc1;
  logic busy2, done2, ld2, isr2, isb2, ark2, imc2;

  always #5 clk = ~clk;

  aes_dec_seq #(.NR(10), .PRE_CYC(10)) u_dut0 (
    .clk(clk), .res(res), .start(start0), .ack(ack0), .cs(cs0), .rnd(rnd0),
    .busy(busy0), .done(done0), .ld(ld0), .isr(isr0), .isb(isb0), .ark(ark0), .imc(imc0));

  aes_dec_seq #(.NR(1), .PRE_CYC(0)) u_dut1 (
    .clk(clk), .res(res), .start(start1), .ack(ack1), .cs(cs1), .rnd(rnd1),
    .busy(busy1), .done(done1), .ld(ld1), .isr(isr1), .isb(isb1), .ark(ark1), .imc(imc1));

  aes_dec_seq #(.NR(10), .PRE_CYC(255)) u_dut2 (
    .clk(clk), .res(res), .start(start2), .ack(ack2), .cs(cs2), .rnd(rnd2),
    .busy(busy2), .done(done2), .ld(ld2), .isr(isr2), .isb(isb2), .ark(ark2), .imc(imc2));

  int checks   = 0;
  int failures = 0;

  // Vector layout: {cs[2:0], rnd[3:0], busy, done, ld, isr, isb, ark, imc}
  logic [13:0] sb_q[$];
  logic [13:0] last_exp;
  int n_ld, n_isr, n_isb, n_ark, n_imc, n_kex, first_done, step_idx;

  function automatic logic [13:0] ev(input logic [2:0] s, input logic [3:0] r);
    logic busy, done;
    busy = (s != 3'd0) && (s != 3'd7);
    done = (s == 3'd7);
    return {s, r, busy, done, s == 3'd2, s == 3'd3, s == 3'd4, s == 3'd5, s == 3'd6};
  endfunction

  function automatic logic [13:0] obs(input int sel);
    case (sel)
      0:       return {cs0, rnd0, busy0, done0, ld0, isr0, isb0, ark0, imc0};
      1:       return {cs1, rnd1, busy1, done1, ld1, isr1, isb1, ark1, imc1};
      default: return {cs2, rnd2, busy2, done2, ld2, isr2, isb2, ark2, imc2};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, o, e);
    end
  endtask

  // Expected trace from the edge that samples start through FIN entry.
  task automatic push_trace(input int nr, input int pre);
    for (int k = 0; k < pre; k++) sb_q.push_back(ev(3'd1, 4'(nr)));
    sb_q.push_back(ev(3'd2, 4'(nr)));
    for (int r = nr - 1; r >= 0; r--) begin
      sb_q.push_back(ev(3'd3, 4'(r)));
      sb_q.push_back(ev(3'd4, 4'(r)));
      sb_q.push_back(ev(3'd5, 4'(r)));
      if (r != 0) sb_q.push_back(ev(3'd6, 4'(r)));
    end
    sb_q.push_back(ev(3'd7, 4'd0));
  endtask

  task automatic clr_tally();
    n_ld = 0; n_isr = 0; n_isb = 0; n_ark = 0; n_imc = 0; n_kex = 0;
    first_done = -1; step_idx = -1;
  endtask

  // Advance one clock, then compare the selected DUT with the queue head.
  task automatic step(input int sel);
    logic [13:0] o;
    @(posedge clk);
    #1;
    step_idx++;
    o = obs(sel);
    if (o[4]) n_ld++;
    if (o[3]) n_isr++;
    if (o[2]) n_isb++;
    if (o[1]) n_ark++;
    if (o[0]) n_imc++;
    if (o[13:11] == 3'd1) n_kex++;
    if (o[5] && first_done < 0) first_done = step_idx;
    if (sb_q.size() == 0) begin
      chk("sb_underflow", 32'd1, 32'd0);
      last_exp = '0;
    end else begin
      last_exp = sb_q.pop_front();
      chk($sformatf("trace_dut%0d_cyc%0d", sel, step_idx), 32'(o), 32'(last_exp));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    res = 1'b0;
    start0 = 1'b0; ack0 = 1'b0;
    start1 = 1'b0; ack1 = 1'b0;
    start2 = 1'b0; ack2 = 1'b0;
    clr_tally();

    // Reset then idle
    repeat (3) @(posedge clk);
    #1;
    chk("reset_dut0", 32'(obs(0)), 32'd0);
    chk("reset_dut1", 32'(obs(1)), 32'd0);
    chk("reset_dut2", 32'(obs(2)), 32'd0);
    res = 1'b1;
    repeat (20) sb_q.push_back(ev(3'd0, 4'd0));
    repeat (20) step(0);

    // Full decrypt with re-pulsed start while busy
    clr_tally();
    start0 = 1'b1;
    push_trace(10, 10);
    for (int i = 0; i < 51; i++) begin
      if (i == 5 || i == 30) start0 = 1'b1;
      step(0);
      start0 = 1'b0;
    end
    chk("latency_dut0", 32'(first_done), 32'd50);
    chk("cnt_ld", 32'(n_ld), 32'd1);
    chk("cnt_isr", 32'(n_isr), 32'd10);
    chk("cnt_isb", 32'(n_isb), 32'd10);
    chk("cnt_ark", 32'(n_ark), 32'd10);
    chk("cnt_imc", 32'(n_imc), 32'd9);

    // FIN hold, then ack and start together
    repeat (15) sb_q.push_back(ev(3'd7, 4'd0));
    repeat (15) step(0);
    ack0 = 1'b1; start0 = 1'b1;
    sb_q.push_back(ev(3'd0, 4'd0));
    step(0);
    ack0 = 1'b0; start0 = 1'b0;
    sb_q.push_back(ev(3'd0, 4'd0));
    step(0);

    // Reset mid-round at IMC with rnd=4
    clr_tally();
    start0 = 1'b1;
    push_trace(10, 10);
    for (int i = 0; i < 60; i++) begin
      step(0);
      start0 = 1'b0;
      if (last_exp == ev(3'd6, 4'd4)) break;
    end
    chk("reached_imc4", 32'(cs0), 32'd6);
    res = 1'b0;
    #2;
    chk("async_reset", 32'(obs(0)), 32'd0);
    sb_q.delete();
    #2;
    res = 1'b1;
    clr_tally();
    start0 = 1'b1;
    push_trace(10, 10);
    for (int i = 0; i < 51; i++) begin
      step(0);
      start0 = 1'b0;
    end
    chk("latency_after_reset", 32'(first_done), 32'd50);
    ack0 = 1'b1;
    sb_q.push_back(ev(3'd0, 4'd0));
    step(0);
    ack0 = 1'b0;

    // NR=1, PRE_CYC=0 corner
    clr_tally();
    start1 = 1'b1;
    push_trace(1, 0);
    for (int i = 0; i < 5; i++) begin
      step(1);
      start1 = 1'b0;
    end
    chk("latency_dut1", 32'(first_done), 32'd4);
    chk("cnt_imc_dut1", 32'(n_imc), 32'd0);
    ack1 = 1'b1;
    sb_q.push_back(ev(3'd0, 4'd0));
    step(1);
    ack1 = 1'b0;

    // PRE_CYC=255 corner
    clr_tally();
    start2 = 1'b1;
    push_trace(10, 255);
    for (int i = 0; sb_q.size() > 0 && i < 400; i++) begin
      step(2);
      start2 = 1'b0;
    end
    chk("kex_len_dut2", 32'(n_kex), 32'd255);
    chk("latency_dut2", 32'(first_done), 32'd295);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
